alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command-side initiator for the 32-bit ALU datapath. It accepts operation commands over a valid/ready interface, decodes each function into ALU control (op, b-invert, carry-in), and drives the ALU operands. It captures the ALU result and carry-out, and returns them over a valid/ready response interface. MUL is built as a 32-iteration shift-add loop on the ALU adder. The block sits between the issue logic and the combinational ALU; the ALU is instantiated at the level above, and this block connects to it through the alu_* ports.

Parameters:
W, 32, datapath width (ALU width; MUL iterates W cycles)
CNT_W, 6, iteration counter width (must hold W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_func  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ANDN, 5 ORN, 6 SLT, 7 MUL
cmd_a  in  W  operand A
cmd_b  in  W  operand B
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  W  result
rsp_carry  out  1  ALU carry-out for ADD/SUB; 0 for all other functions
rsp_zero  out  1  rsp_data == 0
alu_a  out  W  ALU operand a (registered)
alu_b  out  W  ALU operand b (registered)
alu_biv  out  1  ALU b-invert
alu_op  out  2  00 AND, 01 OR, 10 ADD; 11 never driven
alu_cin  out  1  ALU carry-in
alu_result  in  W  ALU result (combinational from alu_* outputs)
alu_cout  in  1  ALU carry-out

Behaviour:
- States: IDLE, EXEC, MUL, RESP. On reset, in any state including mid-MUL:
  - state returns to IDLE;
  - rsp_valid, rsp_data, rsp_carry, alu_a, alu_b, alu_biv, alu_cin and the counter clear to 0;
  - alu_op resets to 00;
  - rsp_zero reads 1 after reset;
  - any command in flight is dropped.
- IDLE: cmd_ready=1. On cmd_valid at edge T, register the operands and the decoded controls.
  - func 7 (MUL) goes to MUL.
  - All other functions go to EXEC.
- Decode (biv, op, cin):
  - ADD (0,10,0); SUB (1,10,1);
  - AND (0,00,0); OR (0,01,0);
  - ANDN (1,00,0); ORN (1,01,0);
  - SLT (1,10,1).
- EXEC (one cycle): capture alu_result and alu_cout, then go to RESP.
  - SLT: rsp_data = {W-1 zeros, lt}, where lt = (a[W-1]^b[W-1]) ? a[W-1] : alu_result[W-1] (signed compare); rsp_carry=0.
- MUL: acc=0, mcand=a, mplr=b.
  - ALU is driven with a=acc, b=mcand, op=ADD, biv=0, cin=0.
  - Each cycle: if mplr[0], acc<=alu_result; mcand<=mcand<<1; mplr<=mplr>>1; counter++.
  - Exit to RESP after exactly W iterations, with no early termination.
  - Result is the low W bits of the unsigned product; rsp_carry=0.
- RESP: rsp_valid=1; rsp_data, rsp_carry and rsp_zero are held stable until rsp_valid && rsp_ready, then go to IDLE.
  - cmd_ready=0 throughout RESP.
  - No same-cycle rsp-accept/cmd-accept overlap; the next command is accepted the following cycle.
- Latency from the accept edge T:
  - single-cycle functions: rsp_valid high in cycle T+2;
  - MUL: rsp_valid high in cycle T+W+1 (T+33 for W=32).
- Throughput: one command per 3 cycles minimum (IDLE, EXEC, RESP).
- alu_* outputs are registered, hold their value outside EXEC/MUL, and are never X after reset.
- Wrap-around: ADD/SUB/MUL are modulo 2^W; the carry reports the ADD/SUB overflow bit only.

Decomposition:
- Shared include alu_defs.vh holds:
  - FUNC_* codes (3-bit);
  - ALU_OP_AND/OR/ADD (2-bit);
  - state encodings.
- One natural sub-module: alu_func_dec. It is purely combinational, mapping func to {biv, op, cin, is_mul, is_slt, use_carry}.
- The FSM, operand registers and MUL loop stay in alu_cmd_sequencer.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001 -> rsp_data=0, carry=1, zero=1, rsp_valid at T+2.
- SUB a=5, b=7 -> 0xFFFFFFFE, carry=0, zero=0; ANDN a=0x0000F0F0, b=0x0000FF00 -> 0x000000F0; ORN a=0, b=0xFFFFFFFE -> 0x00000001.
- SLT a=0x80000000, b=1 -> 1; SLT a=1, b=0x80000000 -> 0; SLT a=b=0x12345678 -> 0, zero=1.
- MUL a=0x00010000, b=0x00010001 -> 0x00010000, rsp_valid first high at T+33, cmd_ready low T+1..T+33.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_data/carry/zero stable, cmd_ready=0, then one handshake -> IDLE, next command accepted the next cycle.
- rst pulsed at MUL iteration 10 -> next cycle IDLE, rsp_valid=0, cmd_ready=1; following ADD 2+3 -> 5 at T+2.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - function codes, ALU op codes, FSM states and decode bundle
package alu_cmd_sequencer_pkg;

  localparam logic [2:0] FUNC_ADD  = 3'd0;
  localparam logic [2:0] FUNC_SUB  = 3'd1;
  localparam logic [2:0] FUNC_AND  = 3'd2;
  localparam logic [2:0] FUNC_OR   = 3'd3;
  localparam logic [2:0] FUNC_ANDN = 3'd4;
  localparam logic [2:0] FUNC_ORN  = 3'd5;
  localparam logic [2:0] FUNC_SLT  = 3'd6;
  localparam logic [2:0] FUNC_MUL  = 3'd7;

  localparam logic [1:0] ALU_OP_AND = 2'b00;
  localparam logic [1:0] ALU_OP_OR  = 2'b01;
  localparam logic [1:0] ALU_OP_ADD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic       biv;
    logic [1:0] op;
    logic       cin;
    logic       is_mul;
    logic       is_slt;
    logic       use_carry;
  } dec_t;

endpackage

// File: rtl/alu_func_dec.sv
// rtl/alu_func_dec.sv - maps a command function code onto ALU controls and result-shaping flags
module alu_func_dec
  import alu_cmd_sequencer_pkg::*;
(
  input  logic [2:0] func,
  output dec_t       dec
);

  always_comb begin
    dec    = '0;
    dec.op = ALU_OP_ADD;
    case (func)
      FUNC_ADD: dec.use_carry = 1'b1;
      FUNC_SUB: begin
        dec.biv       = 1'b1;
        dec.cin       = 1'b1;
        dec.use_carry = 1'b1;
      end
      FUNC_AND: dec.op = ALU_OP_AND;
      FUNC_OR:  dec.op = ALU_OP_OR;
      FUNC_ANDN: begin
        dec.biv = 1'b1;
        dec.op  = ALU_OP_AND;
      end
      FUNC_ORN: begin
        dec.biv = 1'b1;
        dec.op  = ALU_OP_OR;
      end
      // SLT is a subtract whose sign is post-processed by the sequencer
      FUNC_SLT: begin
        dec.biv    = 1'b1;
        dec.cin    = 1'b1;
        dec.is_slt = 1'b1;
      end
      FUNC_MUL: dec.is_mul = 1'b1;
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command/response sequencer driving an external ALU, with shift-add MUL
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_func,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_biv,
  output logic [1:0]       alu_op,
  output logic             alu_cin,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_cout
);

  state_e           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic             alu_biv_q, alu_biv_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic [W-1:0]     mplr_q, mplr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slt_q, slt_d;
  logic             use_carry_q, use_carry_d;
  logic             lt;
  dec_t             dec;

  alu_func_dec u_dec (
    .func (cmd_func),
    .dec  (dec)
  );

  // Signed less-than: differing signs decide directly, otherwise the difference sign does
  assign lt = (alu_a_q[W-1] ^ alu_b_q[W-1]) ? alu_a_q[W-1] : alu_result[W-1];

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_biv_d   = alu_biv_q;
    alu_op_d    = alu_op_q;
    alu_cin_d   = alu_cin_q;
    mplr_d      = mplr_q;
    cnt_d       = cnt_q;
    slt_d       = slt_q;
    use_carry_d = use_carry_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // MUL runs acc + mcand on the adder: a holds the accumulator, b the multiplicand
          alu_a_d     = dec.is_mul ? '0 : cmd_a;
          alu_b_d     = dec.is_mul ? cmd_a : cmd_b;
          alu_biv_d   = dec.biv;
          alu_op_d    = dec.op;
          alu_cin_d   = dec.cin;
          slt_d       = dec.is_slt;
          use_carry_d = dec.use_carry;
          mplr_d      = cmd_b;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          state_d     = dec.is_mul ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = slt_q ? {{(W-1){1'b0}}, lt} : alu_result;
        rsp_carry_d = use_carry_q & alu_cout;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_MUL: begin
        if (mplr_q[0]) begin
          alu_a_d = alu_result;
        end
        alu_b_d = alu_b_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) begin
          rsp_data_d  = mplr_q[0] ? alu_result : alu_a_q;
          rsp_carry_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rsp_zero_d = (rsp_data_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_biv_q   <= 1'b0;
      alu_op_q    <= ALU_OP_AND;
      alu_cin_q   <= 1'b0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      slt_q       <= 1'b0;
      use_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_biv_q   <= alu_biv_d;
      alu_op_q    <= alu_op_d;
      alu_cin_q   <= alu_cin_d;
      mplr_q      <= mplr_d;
      cnt_q       <= cnt_d;
      slt_q       <= slt_d;
      use_carry_q <= use_carry_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_biv   = alu_biv_q;
  assign alu_op    = alu_op_q;
  assign alu_cin   = alu_cin_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized and directed bench with a behavioural reference model
module tb_alu_cmd_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_func;
  logic [W-1:0] cmd_a, cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_carry, rsp_zero;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_biv, alu_cin, alu_cout;
  logic [1:0]   alu_op;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_cmd_sequencer #(.W(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_func   (cmd_func),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_biv    (alu_biv),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout)
  );

  always #5 clk = ~clk;

  // The combinational ALU that sits above the sequencer
  always_comb begin
    logic [W-1:0] bx;
    bx         = alu_biv ? ~alu_b : alu_b;
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_op)
      2'b00: alu_result = alu_a & bx;
      2'b01: alu_result = alu_a | bx;
      2'b10: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, bx} + {{W{1'b0}}, alu_cin};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W:0] ref_calc(input logic [2:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   r;
    logic [W-1:0] m;
    r = '0;
    case (f)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {(a >= b), a - b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a & ~b};
      3'd5: r = {1'b0, a | ~b};
      3'd6: r[0] = ($signed(a) < $signed(b));
      default: begin
        m = a * b;
        r = {1'b0, m};
      end
    endcase
    return r;
  endfunction

  // Reference model: one command in flight, response due a fixed number of cycles after accept
  int           cyc = 0;
  int           due = 0;
  logic         busy = 1'b0;
  logic         started = 1'b0;
  logic [W-1:0] exp_data = '0;
  logic         exp_carry = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      busy    <= 1'b0;
      started <= 1'b1;
    end else if (busy) begin
      if (cyc >= due && rsp_ready) busy <= 1'b0;
    end else if (cmd_valid) begin
      busy      <= 1'b1;
      due       <= cyc + ((cmd_func == 3'd7) ? W + 1 : 2);
      {exp_carry, exp_data} <= ref_calc(cmd_func, cmd_a, cmd_b);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic exp_v;
      exp_v = busy && (cyc >= due);
      chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, !busy});
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
      if (exp_v) begin
        chk("rsp_data", {32'd0, rsp_data}, {32'd0, exp_data});
        chk("rsp_carry", {63'd0, rsp_carry}, {63'd0, exp_carry});
        chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, exp_data == '0});
      end
      chk("alu_known", {63'd0, $isunknown({alu_a, alu_b, alu_biv, alu_op, alu_cin})}, 64'd0);
      chk("alu_op_legal", {63'd0, alu_op == 2'b11}, 64'd0);
    end
  end

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    cmd_func  = f;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int bp, output logic [W-1:0] d, output logic c,
                         output logic z, output int lat);
    issue(f, a, b);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) chk("rsp_timeout", 64'd1, 64'd0);
    d = rsp_data;
    c = rsp_carry;
    z = rsp_zero;
    repeat (bp) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    logic         c, z;
    int           lat;
    logic [2:0]   f;
    logic [W-1:0] a, b;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_func = '0;
    cmd_a = '0;
    cmd_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_rsp_zero", {63'd0, rsp_zero}, 64'd1);
    chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
    chk("reset_alu_op", {62'd0, alu_op}, 64'd0);
    chk("reset_alu_a", {32'd0, alu_a}, 64'd0);

    run_cmd(3'd0, 32'hFFFF_FFFF, 32'h1, 0, d, c, z, lat);
    chk("add_data", {32'd0, d}, 64'd0);
    chk("add_carry", {63'd0, c}, 64'd1);
    chk("add_zero", {63'd0, z}, 64'd1);
    chk("add_latency", 64'(lat), 64'd2);

    run_cmd(3'd1, 32'd5, 32'd7, 0, d, c, z, lat);
    chk("sub_data", {32'd0, d}, 64'hFFFF_FFFE);
    chk("sub_carry", {63'd0, c}, 64'd0);
    chk("sub_zero", {63'd0, z}, 64'd0);

    run_cmd(3'd4, 32'h0000_F0F0, 32'h0000_FF00, 0, d, c, z, lat);
    chk("andn_data", {32'd0, d}, 64'h0000_00F0);
    run_cmd(3'd5, 32'h0, 32'hFFFF_FFFE, 0, d, c, z, lat);
    chk("orn_data", {32'd0, d}, 64'h1);

    run_cmd(3'd6, 32'h8000_0000, 32'h1, 0, d, c, z, lat);
    chk("slt_neg_pos", {32'd0, d}, 64'd1);
    run_cmd(3'd6, 32'h1, 32'h8000_0000, 0, d, c, z, lat);
    chk("slt_pos_neg", {32'd0, d}, 64'd0);
    run_cmd(3'd6, 32'h1234_5678, 32'h1234_5678, 0, d, c, z, lat);
    chk("slt_equal", {32'd0, d}, 64'd0);
    chk("slt_equal_zero", {63'd0, z}, 64'd1);

    run_cmd(3'd7, 32'h0001_0000, 32'h0001_0001, 0, d, c, z, lat);
    chk("mul_data", {32'd0, d}, 64'h0001_0000);
    chk("mul_latency", 64'(lat), 64'd33);

    run_cmd(3'd0, 32'd100, 32'd23, 5, d, c, z, lat);
    chk("bp_data", {32'd0, d}, 64'd123);
    chk("bp_ready_after", {63'd0, cmd_ready}, 64'd1);

    // Reset during MUL iteration 10
    issue(3'd7, 32'hDEAD_BEEF, 32'h1234_5679);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mul_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_mul_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    run_cmd(3'd0, 32'd2, 32'd3, 0, d, c, z, lat);
    chk("post_rst_add", {32'd0, d}, 64'd5);
    chk("post_rst_latency", 64'(lat), 64'd2);

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      if (f == 3'd7 && $urandom_range(0, 2) != 0) f = 3'($urandom_range(0, 6));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'hFFFF_FFFF;
        1: b = a;
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_cmd(f, a, b, $urandom_range(0, 3), d, c, z, lat);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
